lamp_driver: RTL and testbench
==============================

# lamp_driver

Downstream stage of the traffic-light controller. It consumes the three 2-bit color codes (L1 = 4th St, L2/L3 = Harrison both directions) and drives discrete red/yellow/green lamp enables for each signal head. It generates the flash cadence for FLASH codes and runs an independent conflict monitor. The monitor latches a fault on any unsafe or malformed sequence and forces all heads to flashing red until the fault is explicitly cleared.

## Interface
- FLASH_HALF, 1: clocks per flash half-period (lamp on for FLASH_HALF, off for FLASH_HALF); must be ≥1.
- MIN_YELLOW, 5: minimum consecutive sampled YELLOW cycles required before a head may go RED.
- Clock  in  1  system clock (1 Hz tick domain).
- Reset  in  1  synchronous, active-high reset.
- L1, L2, L3  in  2 each  color codes from the controller, shared color type (RED, YELLOW, GREEN, FLASH).
- FaultClear  in  1  request to clear a latched fault; level-sampled.
- Lamp1, Lamp2, Lamp3  out  3 each  lamp enables {R,Y,G}, one-hot or all-off.
- Fault  out  1  latched fault indicator.
- FaultCode  out  2  first fault cause: 00 none, 01 conflict, 10 illegal transition, 11 short yellow.

## Operation
- Decode per head: RED→100, YELLOW→010, GREEN→001, FLASH→{phase,0,0}.
- Flash generator:
  - Free-running counter 0..FLASH_HALF-1.
  - phase toggles when the counter wraps.
  - One phase is shared by all heads, so flashing heads are always in sync.
- Per-head tracking:
  - prev code register.
  - yellow counter, saturating at MIN_YELLOW, width $clog2(MIN_YELLOW+1).
  - Counter increments on each sampled YELLOW. It loads 1 on entry to YELLOW and clears on any non-YELLOW sample.
- Fault detection, evaluated each cycle on the sampled inputs against prev:
  - Conflict: L1 ∈ {GREEN,YELLOW} and (L2 or L3 ∈ {GREEN,YELLOW}). L2/L3 may be non-red together.
  - Illegal transition, any head: GREEN→RED or YELLOW→GREEN. Transitions to or from FLASH are always legal.
  - Short yellow, any head: YELLOW→RED with yellow counter < MIN_YELLOW.
- Fault latch:
  - When no fault is held, the first detection sets Fault=1 and FaultCode to the cause.
  - Same-cycle priority: conflict > illegal > short yellow.
  - Later detections do not change FaultCode.
- While Fault=1:
  - All heads output {phase,0,0} regardless of inputs.
  - prev and yellow tracking continue updating.
- Clear:
  - FaultClear=1 while every sampled L ∈ {RED,FLASH} and no new detection in that cycle → Fault=0, FaultCode=00 at that edge.
  - Otherwise the request is ignored; it is not remembered.

## Timing
- All outputs are registered. An input sampled at edge k appears on Lamp* at edge k (one-clock latency from input change to lamp change).
- Fault and FaultCode assert at the same edge the violating input is sampled. Lamps are forced to flash at that same edge.
- Reset, at the edge Reset is sampled high:
  - Lamp1..3=100; Fault=0; FaultCode=00.
  - phase=1, flash counter=0.
  - prev=FLASH for all heads, so no transition fault on the first sample; yellow counters=0.
- First cycle after Reset deasserts: normal decode. A FLASH input shows red-on for FLASH_HALF cycles, then red-off.
- Reset mid-fault clears the fault unconditionally. Reset overrides FaultClear.
- Flash counter wrap: FLASH_HALF=1 toggles phase every clock.
- Yellow counter saturates; a yellow held longer than MIN_YELLOW is legal.
- Simultaneous conflict and clear request in one cycle → fault stays or sets, clear ignored.

## Test plan
- Normal cycle: reset, then L=(GREEN,RED,RED)×45, (YELLOW,RED,RED)×5, (RED,RED,RED)×1, (RED,GREEN,GREEN)×15, (RED,YELLOW,YELLOW)×5, (RED,RED,RED) → Lamp1=001/010/100 and Lamp2=Lamp3=100/001/010/100 in step, one-cycle latency, Fault=0 throughout.
- Flash: all L=FLASH for 8 cycles, FLASH_HALF=1 → each Lamp alternates 100/000 every cycle, all three identical, Fault=0.
- Conflict: L=(GREEN,GREEN,RED) one cycle → Fault=1, FaultCode=01, all lamps flash red. Returning to legal inputs keeps the fault.
- Short yellow: head 1 GREEN→YELLOW×3→RED → FaultCode=11. Repeat with YELLOW×5 → no fault.
- Illegal transition and clear: head 1 GREEN→RED → FaultCode=10. FaultClear with L1=GREEN → ignored. FaultClear with all RED → Fault=0 next edge, lamps decode normally.
- Reset mid-fault: latch a conflict, assert Reset one cycle → Lamp*=100, Fault=0, FaultCode=00. A subsequent L=(YELLOW,…) after reset raises no transition fault.

Source files
------------

// File: rtl/lamp_driver.sv
// rtl/lamp_driver.sv - lamp decode, flash cadence and conflict monitor for three signal heads
//
// Ports:
//   Clock       system clock (1 Hz tick domain)
//   Reset       synchronous, active-high
//   L1, L2, L3  color codes: 0 RED, 1 YELLOW, 2 GREEN, 3 FLASH (L1 = 4th St, L2/L3 = Harrison)
//   FaultClear  level-sampled request to clear a latched fault
//   Lamp1..3    lamp enables {R,Y,G}
//   Fault       latched fault indicator
//   FaultCode   first cause: 00 none, 01 conflict, 10 illegal transition, 11 short yellow
module lamp_driver #(
    parameter int FLASH_HALF = 1,
    parameter int MIN_YELLOW = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] L1,
    input  logic [1:0] L2,
    input  logic [1:0] L3,
    input  logic       FaultClear,
    output logic [2:0] Lamp1,
    output logic [2:0] Lamp2,
    output logic [2:0] Lamp3,
    output logic       Fault,
    output logic [1:0] FaultCode
);

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        FLASH  = 2'd3
    } color_t;

    localparam int FC_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int YC_W = $clog2(MIN_YELLOW + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_HALF - 1);
    localparam logic [YC_W-1:0] Y_MIN   = YC_W'(MIN_YELLOW);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CODE_SHORT_Y  = 2'b11;

    logic [FC_W-1:0]       fcnt_q, fcnt_d;
    logic                  phase_q, phase_d;
    color_t [2:0]          prev_q, prev_d;
    logic [2:0][YC_W-1:0]  ycnt_q, ycnt_d;
    logic [2:0][2:0]       lamp_q, lamp_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fcode_q, fcode_d;

    color_t [2:0]          cur;
    logic                  conflict;
    logic                  illegal;
    logic                  short_y;
    logic                  all_safe;
    logic                  detect;

    function automatic logic [2:0] decode(input color_t c, input logic ph);
        case (c)
            RED:     decode = 3'b100;
            YELLOW:  decode = 3'b010;
            GREEN:   decode = 3'b001;
            default: decode = {ph, 2'b00};
        endcase
    endfunction

    function automatic logic is_go(input color_t c);
        is_go = (c == GREEN) || (c == YELLOW);
    endfunction

    always_comb begin
        cur[0] = color_t'(L1);
        cur[1] = color_t'(L2);
        cur[2] = color_t'(L3);

        // Shared flash phase: toggles on every counter wrap so all heads blink together.
        if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            fcnt_d  = fcnt_q + FC_W'(1);
            phase_d = phase_q;
        end

        // 4th St may not be moving while either Harrison direction is moving.
        conflict = is_go(cur[0]) && (is_go(cur[1]) || is_go(cur[2]));

        illegal  = 1'b0;
        short_y  = 1'b0;
        all_safe = 1'b1;
        prev_d   = cur;
        ycnt_d   = ycnt_q;
        for (int h = 0; h < 3; h++) begin
            if ((prev_q[h] == GREEN && cur[h] == RED) ||
                (prev_q[h] == YELLOW && cur[h] == GREEN)) begin
                illegal = 1'b1;
            end
            if (prev_q[h] == YELLOW && cur[h] == RED && ycnt_q[h] < Y_MIN) begin
                short_y = 1'b1;
            end
            if (cur[h] != RED && cur[h] != FLASH) begin
                all_safe = 1'b0;
            end
            // Count consecutive yellow samples, saturating so long yellows stay legal.
            if (cur[h] == YELLOW) begin
                if (prev_q[h] != YELLOW) begin
                    ycnt_d[h] = YC_W'(1);
                end else if (ycnt_q[h] != Y_MIN) begin
                    ycnt_d[h] = ycnt_q[h] + YC_W'(1);
                end
            end else begin
                ycnt_d[h] = '0;
            end
        end

        detect = conflict || illegal || short_y;

        fault_d = fault_q;
        fcode_d = fcode_q;
        if (!fault_q) begin
            if (detect) begin
                fault_d = 1'b1;
                if (conflict) begin
                    fcode_d = CODE_CONFLICT;
                end else if (illegal) begin
                    fcode_d = CODE_ILLEGAL;
                end else begin
                    fcode_d = CODE_SHORT_Y;
                end
            end
        end else if (FaultClear && all_safe && !detect) begin
            fault_d = 1'b0;
            fcode_d = CODE_NONE;
        end

        // Lamps follow the fault decision of this same edge, so a violation never shows a
        // single cycle of the unsafe aspect.
        for (int h = 0; h < 3; h++) begin
            lamp_d[h] = fault_d ? {phase_q, 2'b00} : decode(cur[h], phase_q);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b1;
            for (int h = 0; h < 3; h++) begin
                prev_q[h] <= FLASH;
                ycnt_q[h] <= '0;
                lamp_q[h] <= 3'b100;
            end
            fault_q <= 1'b0;
            fcode_q <= CODE_NONE;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            prev_q  <= prev_d;
            ycnt_q  <= ycnt_d;
            lamp_q  <= lamp_d;
            fault_q <= fault_d;
            fcode_q <= fcode_d;
        end
    end

    assign Lamp1     = lamp_q[0];
    assign Lamp2     = lamp_q[1];
    assign Lamp3     = lamp_q[2];
    assign Fault     = fault_q;
    assign FaultCode = fcode_q;

endmodule

// File: tb/tb_lamp_driver.sv
// tb/tb_lamp_driver.sv - self-checking bench for lamp_driver
module tb_lamp_driver;

    localparam int FH = 1;
    localparam int MY = 5;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] F = 2'd3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] L1 = 2'd0;
    logic [1:0] L2 = 2'd0;
    logic [1:0] L3 = 2'd0;
    logic       FaultClear = 1'b0;
    logic [2:0] Lamp1, Lamp2, Lamp3;
    logic       Fault;
    logic [1:0] FaultCode;

    int checks = 0;
    int errors = 0;

    lamp_driver #(.FLASH_HALF(FH), .MIN_YELLOW(MY)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .L1         (L1),
        .L2         (L2),
        .L3         (L3),
        .FaultClear (FaultClear),
        .Lamp1      (Lamp1),
        .Lamp2      (Lamp2),
        .Lamp3      (Lamp3),
        .Fault      (Fault),
        .FaultCode  (FaultCode)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Reference model: cycles since reset give the flash phase, raw yellow run lengths give
    // the short-yellow rule.
    int         m_n = 0;
    logic [1:0] m_prev [3];
    int         m_run [3];
    logic       m_fault = 1'b0;
    logic [1:0] m_code = 2'b00;
    logic       m_valid = 1'b0;
    logic [2:0] e_lamp [3];

    always @(posedge Clock) begin : model
        logic [1:0] s [3];
        logic ph, conf, ill, shrt, safe;
        s[0] = L1;
        s[1] = L2;
        s[2] = L3;
        if (Reset) begin
            m_n = 0;
            m_fault = 1'b0;
            m_code = 2'b00;
            m_valid = 1'b1;
            for (int h = 0; h < 3; h++) begin
                m_prev[h] = F;
                m_run[h] = 0;
                e_lamp[h] = 3'b100;
            end
        end else begin
            ph = ((m_n / FH) % 2) == 0;
            conf = (s[0] == G || s[0] == Y) &&
                   (s[1] == G || s[1] == Y || s[2] == G || s[2] == Y);
            ill = 1'b0;
            shrt = 1'b0;
            safe = 1'b1;
            for (int h = 0; h < 3; h++) begin
                if ((m_prev[h] == G && s[h] == R) || (m_prev[h] == Y && s[h] == G)) ill = 1'b1;
                if (m_prev[h] == Y && s[h] == R && m_run[h] < MY) shrt = 1'b1;
                if (!(s[h] == R || s[h] == F)) safe = 1'b0;
                m_run[h] = (s[h] == Y) ? m_run[h] + 1 : 0;
                m_prev[h] = s[h];
            end
            if (!m_fault) begin
                if (conf) begin
                    m_fault = 1'b1; m_code = 2'b01;
                end else if (ill) begin
                    m_fault = 1'b1; m_code = 2'b10;
                end else if (shrt) begin
                    m_fault = 1'b1; m_code = 2'b11;
                end
            end else if (FaultClear && safe && !(conf || ill || shrt)) begin
                m_fault = 1'b0;
                m_code = 2'b00;
            end
            for (int h = 0; h < 3; h++) begin
                if (m_fault || s[h] == F) e_lamp[h] = {ph, 2'b00};
                else if (s[h] == R)       e_lamp[h] = 3'b100;
                else if (s[h] == Y)       e_lamp[h] = 3'b010;
                else                      e_lamp[h] = 3'b001;
            end
            m_n++;
        end
        #1;
        if (m_valid) begin
            chk("model_lamp1", {5'd0, Lamp1}, {5'd0, e_lamp[0]});
            chk("model_lamp2", {5'd0, Lamp2}, {5'd0, e_lamp[1]});
            chk("model_lamp3", {5'd0, Lamp3}, {5'd0, e_lamp[2]});
            chk("model_fault", {7'd0, Fault}, {7'd0, m_fault});
            chk("model_code",  {6'd0, FaultCode}, {6'd0, m_code});
        end
    end

    task automatic cyc(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic clr, input logic rst);
        @(negedge Clock);
        L1 = a; L2 = b; L3 = c; FaultClear = clr; Reset = rst;
        @(posedge Clock);
        #2;
    endtask

    task automatic rep(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) cyc(a, b, c, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        cyc(R, R, R, 1'b0, 1'b1);
        cyc(R, R, R, 1'b0, 1'b1);
        chk("rst_lamp1", {5'd0, Lamp1}, 8'b100);
        chk("rst_fault", {7'd0, Fault}, 8'd0);
        chk("rst_code", {6'd0, FaultCode}, 8'd0);

        // Normal cycle
        rep(G, R, R, 1);
        chk("norm_l1_green", {5'd0, Lamp1}, 8'b001);
        chk("norm_l2_red", {5'd0, Lamp2}, 8'b100);
        rep(G, R, R, 44);
        rep(Y, R, R, 5);
        chk("norm_l1_yellow", {5'd0, Lamp1}, 8'b010);
        rep(R, R, R, 1);
        rep(R, G, G, 15);
        chk("norm_l3_green", {5'd0, Lamp3}, 8'b001);
        rep(R, Y, Y, 5);
        rep(R, R, R, 1);
        chk("norm_l2_red_end", {5'd0, Lamp2}, 8'b100);
        chk("norm_fault", {7'd0, Fault}, 8'd0);

        // Flash from a fresh reset: red-on first, then off
        cyc(R, R, R, 1'b0, 1'b1);
        rep(F, F, F, 1);
        chk("flash_on", {5'd0, Lamp1}, 8'b100);
        rep(F, F, F, 1);
        chk("flash_off", {5'd0, Lamp2}, 8'b000);
        rep(F, F, F, 6);
        chk("flash_8th", {5'd0, Lamp3}, 8'b000);
        chk("flash_fault", {7'd0, Fault}, 8'd0);

        // Conflict, held after inputs become legal
        rep(G, G, R, 1);
        chk("conf_fault", {7'd0, Fault}, 8'd1);
        chk("conf_code", {6'd0, FaultCode}, 8'b01);
        chk("conf_lamp2", {5'd0, Lamp2}, 8'b100);
        rep(R, R, R, 1);
        chk("conf_held", {7'd0, Fault}, 8'd1);
        chk("conf_code_held", {6'd0, FaultCode}, 8'b01);
        chk("conf_lamp1_off", {5'd0, Lamp1}, 8'b000);

        // Short yellow, clear, then legal yellow
        cyc(R, R, R, 1'b0, 1'b1);
        rep(G, R, R, 1);
        rep(Y, R, R, 3);
        rep(R, R, R, 1);
        chk("short_code", {6'd0, FaultCode}, 8'b11);
        cyc(R, R, R, 1'b1, 1'b0);
        chk("short_clear", {7'd0, Fault}, 8'd0);
        chk("short_clear_code", {6'd0, FaultCode}, 8'b00);
        rep(G, R, R, 1);
        rep(Y, R, R, 5);
        rep(R, R, R, 1);
        chk("long_yellow_ok", {7'd0, Fault}, 8'd0);

        // Illegal transition and clear handling
        rep(G, R, R, 1);
        rep(R, R, R, 1);
        chk("illegal_code", {6'd0, FaultCode}, 8'b10);
        cyc(G, R, R, 1'b1, 1'b0);
        chk("clear_unsafe_ignored", {7'd0, Fault}, 8'd1);
        cyc(R, R, R, 1'b1, 1'b0);
        chk("clear_detect_ignored", {7'd0, Fault}, 8'd1);
        cyc(R, R, R, 1'b1, 1'b0);
        chk("clear_ok", {7'd0, Fault}, 8'd0);
        rep(G, R, R, 1);
        chk("after_clear_green", {5'd0, Lamp1}, 8'b001);

        // Conflict with simultaneous clear, then reset mid-fault
        cyc(G, G, R, 1'b1, 1'b0);
        chk("conf_clr_fault", {7'd0, Fault}, 8'd1);
        chk("conf_clr_code", {6'd0, FaultCode}, 8'b01);
        cyc(R, R, R, 1'b1, 1'b1);
        chk("midrst_lamp1", {5'd0, Lamp1}, 8'b100);
        chk("midrst_fault", {7'd0, Fault}, 8'd0);
        chk("midrst_code", {6'd0, FaultCode}, 8'b00);
        rep(Y, R, R, 1);
        chk("post_rst_yellow", {5'd0, Lamp1}, 8'b010);
        chk("post_rst_nofault", {7'd0, Fault}, 8'd0);

        @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
